// File: rtl/operand_gen_pipe_if.sv
// Bus between the ID-stage operand generator and its neighbours: decode inputs,
// forwarding ports, and the valid/ready handshakes on both sides.
interface operand_gen_pipe_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int FWD_PORTS   = 2,
    parameter int STALL_CNT_W = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [ADDR_WIDTH-1:0]         addr;
    logic [5:0]                    op;
    logic [5:0]                    funct;
    logic [15:0]                   imm;
    logic [4:0]                    rs_addr;
    logic [4:0]                    rt_addr;
    logic [DATA_WIDTH-1:0]         reg_data_1;
    logic [DATA_WIDTH-1:0]         reg_data_2;
    logic [FWD_PORTS-1:0]          fwd_en;
    logic [5*FWD_PORTS-1:0]        fwd_addr;
    logic [DATA_WIDTH*FWD_PORTS-1:0] fwd_data;
    logic [FWD_PORTS-1:0]          fwd_pending;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         operand_1;
    logic [DATA_WIDTH-1:0]         operand_2;
    logic                          stall_req;
    logic [STALL_CNT_W-1:0]        stall_cycles;

    modport master (
        output in_valid, addr, op, funct, imm, rs_addr, rt_addr,
               reg_data_1, reg_data_2, fwd_en, fwd_addr, fwd_data, fwd_pending,
               flush, out_ready,
        input  in_ready, out_valid, operand_1, operand_2, stall_req, stall_cycles
    );

    modport slave (
        input  in_valid, addr, op, funct, imm, rs_addr, rt_addr,
               reg_data_1, reg_data_2, fwd_en, fwd_addr, fwd_data, fwd_pending,
               flush, out_ready,
        output in_ready, out_valid, operand_1, operand_2, stall_req, stall_cycles
    );
endinterface

// File: rtl/operand_gen_pipe.sv
// ID-stage operand generator: decode-driven operand select, forwarding with
// load-use hazard detection, and a single-entry valid/ready ID/EX register.
module operand_gen_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINK_OFFSET = 8,
    parameter int FWD_PORTS   = 2,
    parameter int STALL_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    operand_gen_pipe_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [1:0] {SEL1_ZERO, SEL1_SRC, SEL1_LINK} sel1_e;
    typedef enum logic [2:0] {SEL2_ZERO, SEL2_SRC, SEL2_SEXT, SEL2_ZEXT, SEL2_LUI} sel2_e;

    sel1_e                  w_sel1;
    sel2_e                  w_sel2;
    logic [ADDR_WIDTH-1:0]  w_link_addr;
    logic [DATA_WIDTH-1:0]  w_link;
    logic [DATA_WIDTH-1:0]  w_src1;
    logic [DATA_WIDTH-1:0]  w_src2;
    logic                   w_pend1;
    logic                   w_pend2;
    logic                   w_stall;
    logic                   w_in_ready;
    logic                   w_accept;
    logic [DATA_WIDTH-1:0]  w_op1;
    logic [DATA_WIDTH-1:0]  w_op2;

    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_op1;
    logic [DATA_WIDTH-1:0]  r_op2;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_comb begin
        w_sel1 = SEL1_ZERO;
        w_sel2 = SEL2_ZERO;
        case (bus.op)
            OP_SPECIAL: begin
                if (bus.funct == FN_JALR) begin
                    w_sel1 = SEL1_LINK;
                end else begin
                    w_sel1 = SEL1_SRC;
                    w_sel2 = SEL2_SRC;
                end
            end
            OP_JAL: w_sel1 = SEL1_LINK;
            OP_ADDI, OP_ADDIU, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SW: begin
                w_sel1 = SEL1_SRC;
                w_sel2 = SEL2_SEXT;
            end
            OP_LUI: begin
                w_sel1 = SEL1_SRC;
                w_sel2 = SEL2_LUI;
            end
            OP_ANDI, OP_ORI: begin
                w_sel1 = SEL1_SRC;
                w_sel2 = SEL2_ZEXT;
            end
            default: ;
        endcase
    end

    // Scan from the oldest port down so the youngest matching port wins.
    always_comb begin
        w_src1  = bus.reg_data_1;
        w_src2  = bus.reg_data_2;
        w_pend1 = 1'b0;
        w_pend2 = 1'b0;
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (bus.fwd_en[i] && (bus.rs_addr != 5'd0) && (bus.fwd_addr[5*i +: 5] == bus.rs_addr)) begin
                w_src1  = bus.fwd_data[DATA_WIDTH*i +: DATA_WIDTH];
                w_pend1 = bus.fwd_pending[i];
            end
            if (bus.fwd_en[i] && (bus.rt_addr != 5'd0) && (bus.fwd_addr[5*i +: 5] == bus.rt_addr)) begin
                w_src2  = bus.fwd_data[DATA_WIDTH*i +: DATA_WIDTH];
                w_pend2 = bus.fwd_pending[i];
            end
        end
    end

    assign w_link_addr = bus.addr + ADDR_WIDTH'(LINK_OFFSET);
    assign w_link      = DATA_WIDTH'(w_link_addr);

    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (w_sel1)
            SEL1_SRC:  w_op1 = w_src1;
            SEL1_LINK: w_op1 = w_link;
            default:   w_op1 = '0;
        endcase
        case (w_sel2)
            SEL2_SRC:  w_op2 = w_src2;
            SEL2_SEXT: w_op2 = DATA_WIDTH'($signed(bus.imm));
            SEL2_ZEXT: w_op2 = DATA_WIDTH'(bus.imm);
            SEL2_LUI:  w_op2 = DATA_WIDTH'({bus.imm, 16'h0000});
            default:   w_op2 = '0;
        endcase
    end

    assign w_stall    = bus.in_valid && !bus.flush &&
                        (((w_sel1 == SEL1_SRC) && w_pend1) || ((w_sel2 == SEL2_SRC) && w_pend2));
    assign w_in_ready = !w_stall && (!r_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
            // Flush kills the held entry but leaves the operand registers untouched.
            if (bus.flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_op1   <= w_op1;
                r_op2   <= w_op2;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.stall_req    = w_stall;
    assign bus.out_valid    = r_valid;
    assign bus.operand_1    = r_op1;
    assign bus.operand_2    = r_op2;
    assign bus.stall_cycles = r_stall_cnt;
endmodule
